// File: rtl/operand_fetch_if.sv
// Bundles the instruction, writeback, register-file and operand buses of operand_fetch.
// The master modport is the surrounding pipeline and register file; the slave is the sequencer.
`timescale 1ns/1ps
interface operand_fetch_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] instr_rs1;
  logic [ADDR_W-1:0] instr_rs2;
  logic [ADDR_W-1:0] instr_rd;

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [WIDTH-1:0]  wb_data;

  logic              rf_en;
  logic              rf_r_or_w;
  logic [ADDR_W-1:0] rf_addr;
  logic [WIDTH-1:0]  rf_wdata;
  logic [WIDTH-1:0]  rf_rdata;

  logic              op_valid;
  logic              op_ready;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [ADDR_W-1:0] op_rd;

  modport master (
    output instr_valid, instr_rs1, instr_rs2, instr_rd,
    input  instr_ready,
    output wb_valid, wb_addr, wb_data,
    input  wb_ready,
    input  rf_en, rf_r_or_w, rf_addr, rf_wdata,
    output rf_rdata,
    input  op_valid, op_a, op_b, op_rd,
    output op_ready
  );

  modport slave (
    input  instr_valid, instr_rs1, instr_rs2, instr_rd,
    output instr_ready,
    input  wb_valid, wb_addr, wb_data,
    output wb_ready,
    output rf_en, rf_r_or_w, rf_addr, rf_wdata,
    input  rf_rdata,
    output op_valid, op_a, op_b, op_rd,
    input  op_ready
  );
endinterface

// File: rtl/operand_fetch.sv
// Serialises writebacks and two-operand reads onto a single-port register file and hands the
// captured operands to execute over a valid/ready handshake.
`timescale 1ns/1ps
module operand_fetch #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input logic           clk,
  input logic           rst,
  operand_fetch_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReadA, StReadB, StHold} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic [ADDR_W-1:0] op_rd_q, op_rd_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;

  logic              wb_go;
  logic              rf_en, rf_r_or_w;
  logic [ADDR_W-1:0] rf_addr;
  logic [WIDTH-1:0]  rf_wdata;
  logic              instr_ready, wb_ready, op_valid;

  always_comb begin
    state_d     = state_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    op_rd_d     = op_rd_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    wb_go       = 1'b0;
    rf_en       = 1'b0;
    rf_r_or_w   = 1'b0;
    rf_addr     = '0;
    rf_wdata    = '0;
    instr_ready = 1'b0;
    wb_ready    = 1'b0;
    op_valid    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.wb_valid) begin
          // Writeback beats a simultaneous instruction; no write may escape while in reset.
          wb_go = !rst;
        end else begin
          instr_ready = 1'b1;
          if (bus.instr_valid) begin
            rs1_d   = bus.instr_rs1;
            rs2_d   = bus.instr_rs2;
            op_rd_d = bus.instr_rd;
            state_d = StReadA;
          end
        end
      end
      StReadA: begin
        rf_en   = 1'b1;
        rf_addr = rs1_q;
        op_a_d  = bus.rf_rdata;
        if (rs1_q == rs2_q) begin
          op_b_d  = bus.rf_rdata;
          state_d = StHold;
        end else begin
          state_d = StReadB;
        end
      end
      StReadB: begin
        rf_en   = 1'b1;
        rf_addr = rs2_q;
        op_b_d  = bus.rf_rdata;
        state_d = StHold;
      end
      StHold: begin
        op_valid = 1'b1;
        if (bus.wb_valid) begin
          wb_go = 1'b1;
          // A transfer this cycle carries the pre-write values, so only bypass when stalled.
          if (!bus.op_ready) begin
            if (bus.wb_addr == rs1_q) op_a_d = bus.wb_data;
            if (bus.wb_addr == rs2_q) op_b_d = bus.wb_data;
          end
        end
        if (bus.op_ready) state_d = StIdle;
      end
    endcase

    if (wb_go) begin
      wb_ready  = 1'b1;
      rf_en     = 1'b1;
      rf_r_or_w = 1'b1;
      rf_addr   = bus.wb_addr;
      rf_wdata  = bus.wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rs1_q   <= '0;
      rs2_q   <= '0;
      op_rd_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      op_rd_q <= op_rd_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  assign bus.rf_en       = rf_en;
  assign bus.rf_r_or_w   = rf_r_or_w;
  assign bus.rf_addr     = rf_addr;
  assign bus.rf_wdata    = rf_wdata;
  assign bus.instr_ready = instr_ready;
  assign bus.wb_ready    = wb_ready;
  assign bus.op_valid    = op_valid;
  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;
  assign bus.op_rd       = op_rd_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a behavioural register file, a table of fetches and
// hand-written sequences for collisions, backpressure/bypass, transfer+writeback and reset.
`timescale 1ns/1ps
module tb_operand_fetch;

  logic clk;
  logic rst;

  operand_fetch_if #(.WIDTH(16), .ADDR_W(4)) bus ();

  operand_fetch #(.WIDTH(16), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port register file: combinational read, write on the rising edge.
  logic [15:0] regs [16];
  always @(posedge clk) begin
    if (bus.rf_en && bus.rf_r_or_w) regs[bus.rf_addr] <= bus.rf_wdata;
  end
  assign bus.rf_rdata = (bus.rf_en && !bus.rf_r_or_w) ? regs[bus.rf_addr] : 16'h0000;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wb_t;

  typedef struct {
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
  } vec_t;

  task automatic do_wb(input logic [3:0] addr, input logic [15:0] data);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = addr;
    bus.wb_data  = data;
    settle();
    check("wb_ready_idle", {31'b0, bus.wb_ready}, 32'd1);
    check("wb_rf_addr", {28'b0, bus.rf_addr}, {28'b0, addr});
    step();
    bus.wb_valid = 1'b0;
  endtask

  // Full fetch with op_ready held high; checks the per-cycle read sequence and latency.
  task automatic run_instr(input vec_t v);
    bus.op_ready    = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr_rs1   = v.rs1;
    bus.instr_rs2   = v.rs2;
    bus.instr_rd    = v.rd;
    settle();
    check("instr_ready_idle", {31'b0, bus.instr_ready}, 32'd1);
    step();
    bus.instr_valid = 1'b0;
    settle();
    check("read_a_en", {30'b0, bus.rf_en, bus.rf_r_or_w}, 32'b10);
    check("read_a_addr", {28'b0, bus.rf_addr}, {28'b0, v.rs1});
    check("read_a_no_valid", {30'b0, bus.op_valid, bus.instr_ready}, 32'b00);
    step();
    if (v.rs1 != v.rs2) begin
      settle();
      check("read_b_en", {30'b0, bus.rf_en, bus.rf_r_or_w}, 32'b10);
      check("read_b_addr", {28'b0, bus.rf_addr}, {28'b0, v.rs2});
      check("read_b_no_valid", {31'b0, bus.op_valid}, 32'd0);
      step();
    end
    settle();
    check("hold_valid", {31'b0, bus.op_valid}, 32'd1);
    check("hold_op_a", {16'b0, bus.op_a}, {16'b0, v.a});
    check("hold_op_b", {16'b0, bus.op_b}, {16'b0, v.b});
    check("hold_op_rd", {28'b0, bus.op_rd}, {28'b0, v.rd});
    check("hold_rf_idle", {31'b0, bus.rf_en}, 32'd0);
    step();
    settle();
    check("after_xfer_idle", {30'b0, bus.op_valid, bus.instr_ready}, 32'b01);
  endtask

  wb_t  pre  [6];
  vec_t vecs [5];

  initial begin
    pre[0] = '{addr: 4'd3,  data: 16'h1234};
    pre[1] = '{addr: 4'd5,  data: 16'hBEEF};
    pre[2] = '{addr: 4'd2,  data: 16'h0042};
    pre[3] = '{addr: 4'd1,  data: 16'h1111};
    pre[4] = '{addr: 4'd0,  data: 16'h0F0F};
    pre[5] = '{addr: 4'd15, data: 16'hFFFF};

    vecs[0] = '{rs1: 4'd3,  rs2: 4'd5,  rd: 4'd7,  a: 16'h1234, b: 16'hBEEF};
    vecs[1] = '{rs1: 4'd2,  rs2: 4'd2,  rd: 4'd9,  a: 16'h0042, b: 16'h0042};
    vecs[2] = '{rs1: 4'd5,  rs2: 4'd3,  rd: 4'd0,  a: 16'hBEEF, b: 16'h1234};
    vecs[3] = '{rs1: 4'd15, rs2: 4'd0,  rd: 4'd15, a: 16'hFFFF, b: 16'h0F0F};
    vecs[4] = '{rs1: 4'd1,  rs2: 4'd15, rd: 4'd1,  a: 16'h1111, b: 16'hFFFF};

    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_rs1   = '0;
    bus.instr_rs2   = '0;
    bus.instr_rd    = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.op_ready    = 1'b0;

    // Reset values.
    #2;
    check("rst_op_valid", {31'b0, bus.op_valid}, 32'd0);
    check("rst_ops", {bus.op_a, bus.op_b}, 32'd0);
    check("rst_op_rd", {28'b0, bus.op_rd}, 32'd0);
    check("rst_rf", {bus.rf_en, bus.rf_r_or_w, bus.rf_addr, bus.rf_wdata}, 32'd0);
    check("rst_instr_ready", {31'b0, bus.instr_ready}, 32'd1);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 4'd9;
    bus.wb_data  = 16'hDEAD;
    settle();
    check("rst_wb_blocks_instr", {31'b0, bus.instr_ready}, 32'd0);
    check("rst_no_write", {30'b0, bus.rf_en, bus.wb_ready}, 32'd0);
    bus.wb_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    settle();

    for (int i = 0; i < 6; i++) do_wb(pre[i].addr, pre[i].data);
    for (int i = 0; i < 5; i++) run_instr(vecs[i]);

    // Collision in IDLE: writeback first, instruction one cycle later.
    bus.wb_valid    = 1'b1;
    bus.wb_addr     = 4'd4;
    bus.wb_data     = 16'hA5A5;
    bus.instr_valid = 1'b1;
    bus.instr_rs1   = 4'd4;
    bus.instr_rs2   = 4'd1;
    bus.instr_rd    = 4'd6;
    settle();
    check("coll_instr_ready", {31'b0, bus.instr_ready}, 32'd0);
    check("coll_write", {30'b0, bus.wb_ready, bus.rf_r_or_w}, 32'b11);
    check("coll_wdata", {16'b0, bus.rf_wdata}, 32'h0000A5A5);
    step();
    bus.wb_valid = 1'b0;
    run_instr('{rs1: 4'd4, rs2: 4'd1, rd: 4'd6, a: 16'hA5A5, b: 16'h1111});

    // Backpressure with a writeback stalled through both reads, then bypassed into op_b.
    bus.op_ready    = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr_rs1   = 4'd3;
    bus.instr_rs2   = 4'd5;
    bus.instr_rd    = 4'd8;
    settle();
    step();
    bus.instr_valid = 1'b0;
    bus.wb_valid    = 1'b1;
    bus.wb_addr     = 4'd5;
    bus.wb_data     = 16'h00FF;
    settle();
    check("bp_wb_stall_a", {27'b0, bus.wb_ready, bus.rf_r_or_w, bus.rf_addr}, 32'h3);
    step();
    settle();
    check("bp_wb_stall_b", {27'b0, bus.wb_ready, bus.rf_r_or_w, bus.rf_addr}, 32'h5);
    step();
    settle();
    check("bp_hold_write", {29'b0, bus.op_valid, bus.wb_ready, bus.rf_r_or_w}, 32'b111);
    check("bp_pre_bypass_b", {16'b0, bus.op_b}, 32'h0000BEEF);
    step();
    bus.wb_valid = 1'b0;
    settle();
    check("bp_bypass_b", {16'b0, bus.op_b}, 32'h000000FF);
    check("bp_keep_a", {16'b0, bus.op_a}, 32'h00001234);
    for (int i = 0; i < 3; i++) begin
      step();
      settle();
      check("bp_stable", {15'b0, bus.op_valid, bus.op_b}, 32'h000100FF);
    end
    bus.op_ready = 1'b1;
    step();
    settle();
    check("bp_released", {31'b0, bus.op_valid}, 32'd0);
    check("bp_rf_written", {16'b0, regs[5]}, 32'h000000FF);

    // Transfer and writeback to rs1 in the same HOLD cycle.
    bus.op_ready    = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr_rs1   = 4'd2;
    bus.instr_rs2   = 4'd3;
    bus.instr_rd    = 4'd10;
    settle();
    step();
    bus.instr_valid = 1'b0;
    step();
    step();
    settle();
    check("tw_hold_a", {15'b0, bus.op_valid, bus.op_a}, 32'h00010042);
    bus.op_ready = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 4'd2;
    bus.wb_data  = 16'h7777;
    settle();
    check("tw_xfer_old_a", {15'b0, bus.wb_ready, bus.op_a}, 32'h00010042);
    step();
    bus.wb_valid = 1'b0;
    settle();
    check("tw_to_idle", {30'b0, bus.op_valid, bus.instr_ready}, 32'b01);
    check("tw_no_bypass", {16'b0, bus.op_a}, 32'h00000042);
    check("tw_rf_written", {16'b0, regs[2]}, 32'h00007777);

    // Reset asserted during READ_B.
    bus.instr_valid = 1'b1;
    bus.instr_rs1   = 4'd1;
    bus.instr_rs2   = 4'd3;
    bus.instr_rd    = 4'd5;
    settle();
    step();
    bus.instr_valid = 1'b0;
    step();
    settle();
    check("mr_in_read_b", {27'b0, bus.rf_en, bus.rf_addr}, 32'h13);
    rst = 1'b1;
    settle();
    check("mr_rf_zero", {bus.rf_en, bus.rf_r_or_w, bus.rf_addr, bus.rf_wdata}, 32'd0);
    check("mr_ops_zero", {bus.op_a, bus.op_b}, 32'd0);
    check("mr_valid_rd_zero", {27'b0, bus.op_valid, bus.op_rd}, 32'd0);
    step();
    rst = 1'b0;
    settle();
    check("mr_instr_ready", {31'b0, bus.instr_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      settle();
      check("mr_no_pulse", {30'b0, bus.op_valid, bus.rf_en}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Sequencer that sits directly upstream of the single-port `registers` file and is its only master. It accepts decoded instructions (two source addresses, one destination) and writeback requests, serialises them onto the register file's one `en`/`r_or_w`/`reg_addr` port, captures both source operands, and presents them with the destination address to the execute stage over a valid/ready handshake. Register file reads are combinational: data is valid in the same cycle the address is driven and is captured at the next `clk` edge.

## Interface
- `WIDTH`, 16, data width; must match the register file.
- `ADDR_W`, 4, register address width; 16 registers.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_valid` in 1: instruction offered.
- `instr_ready` out 1: instruction accepted on an edge where both are high.
- `instr_rs1`, `instr_rs2`, `instr_rd` in ADDR_W each: source A, source B and destination addresses.
- `wb_valid` in 1: writeback offered.
- `wb_ready` out 1: writeback performed on an edge where both are high.
- `wb_addr` in ADDR_W, `wb_data` in WIDTH: writeback target and value.
- `rf_en` out 1: register file enable.
- `rf_r_or_w` out 1: 1 = write, 0 = read.
- `rf_addr` out ADDR_W: register file address.
- `rf_wdata` out WIDTH: register file write data.
- `rf_rdata` in WIDTH: register file read data.
- `op_valid` out 1, `op_ready` in 1: operand handshake to execute.
- `op_a`, `op_b` out WIDTH; `op_rd` out ADDR_W: captured operands and destination.

## Operation
- **States:** IDLE, READ_A, READ_B, HOLD.
- **IDLE:**
  - If `wb_valid` is high: `wb_ready`=1, `rf_en`=1, `rf_r_or_w`=1, `rf_addr`=`wb_addr`, `rf_wdata`=`wb_data`; `instr_ready`=0. Stay in IDLE.
  - Otherwise `instr_ready`=1. On `instr_valid`, latch rs1, rs2 and rd (rd goes to `op_rd`), then go to READ_A.
  - Writeback always wins over a simultaneous instruction.
- **READ_A:**
  - Drive `rf_en`=1, `rf_r_or_w`=0, `rf_addr`=rs1.
  - At the edge, `op_a`<=`rf_rdata`.
  - If rs2==rs1, also `op_b`<=`rf_rdata` and go to HOLD. Otherwise go to READ_B.
- **READ_B:**
  - Drive a read of rs2.
  - At the edge, `op_b`<=`rf_rdata`; go to HOLD.
- **HOLD:**
  - `op_valid`=1. `op_a`, `op_b` and `op_rd` are stable unless bypassed (below).
  - On `op_ready`, go to IDLE.
- **Writeback in HOLD:**
  - `wb_ready`=1 and the write is driven exactly as in IDLE.
  - Bypass when `op_ready` is low: if `wb_addr`==rs1, `op_a`<=`wb_data`. If `wb_addr`==rs2, `op_b`<=`wb_data`. Both apply if rs1==rs2.
  - If `op_ready` is high in the same cycle, the transfer carries the pre-write values, the write still happens, and the state goes to IDLE.
- **Writeback in READ_A/READ_B:** `wb_ready`=0 and the writeback stalls.
- **Register file port idle:** whenever `rf_en`=0, `rf_r_or_w`, `rf_addr` and `rf_wdata` are driven 0.
- **Combinational outputs:** `rf_*`, `instr_ready`, `wb_ready` and `op_valid` are decoded from the state and inputs only; there is no combinational path from `op_ready` to any `rf_*` output.

## Timing
- **Reset:** state IDLE; `op_valid`, `op_a`, `op_b`, `op_rd` and all `rf_*` outputs are 0. `instr_ready` equals `!wb_valid`.
- **Reset mid-operation:** the instruction is dropped with no partial `op_valid`, and `rf_en` falls immediately, asynchronously.
- **Latency:**
  - Instruction accepted at edge N: READ_A in cycle N+1, READ_B in cycle N+2, `op_valid` high from cycle N+3 (after edge N+2).
  - When rs1==rs2, `op_valid` is high from cycle N+2.
- **Throughput:** one instruction per 4 cycles minimum (3 when rs1==rs2), with `op_ready` held high and no writebacks.
- **Writeback latency:** zero-wait in IDLE/HOLD; stalled for at most 2 cycles during reads.
- **Handshake rules:** `op_valid` never falls without `op_ready`. `instr_ready` is never high outside IDLE.

## Test plan
- **Reset mid-read:** assert `rst` during READ_B → all outputs 0 within the same cycle. After release, `instr_ready`=1 with `wb_valid`=0, and no `op_valid` pulse.
- **Normal fetch:** writeback r3=0x1234, r5=0xBEEF, then instruction rs1=3, rs2=5, rd=7 → `rf_addr` 3 then 5 with `rf_r_or_w`=0, then `op_valid`=1 two edges after acceptance with `op_a`=0x1234, `op_b`=0xBEEF, `op_rd`=7.
- **Same source:** rs1=rs2=2 with r2=0x0042 → exactly one read cycle; `op_valid` one edge after acceptance; `op_a`=`op_b`=0x0042.
- **Collision in IDLE:** `wb_valid` (r4=0xA5A5) and `instr_valid` (rs1=4, rs2=1) in the same cycle → write first with `instr_ready`=0; instruction accepted the next cycle and `op_a`=0xA5A5.
- **Backpressure and bypass:** hold `op_ready`=0 for 5 cycles in HOLD; writeback rs2's address with 0x00FF → `op_b`=0x00FF, `op_a` unchanged, `op_valid` stays 1. A writeback offered during READ_A sees `wb_ready`=0 until HOLD.
- **Transfer plus writeback:** `op_ready` and `wb_valid` to rs1 in the same HOLD cycle → execute receives the old `op_a`, the register file is written, and the next state is IDLE.
